// File: rtl/apb_slave_regs.sv
// rtl/apb_slave_regs.sv - APB completer with three R/W registers, a write counter and wait states
module apb_slave_regs #(
    parameter int                    ADDR_WIDTH  = 2,
    parameter int                    DATA_WIDTH  = 2,
    parameter int                    WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslave_error
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  capture_en;
    logic                  commit;
    logic [1:0]            cap_addr_q;
    logic                  cap_write_q;
    logic [DATA_WIDTH-1:0] cap_wdata_q;
    logic [DATA_WIDTH-1:0] regs_q [3];
    logic [DATA_WIDTH-1:0] wcnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture_en = 1'b0;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                // An access phase without a preceding setup phase is ignored.
                if (pselx && !penable) begin
                    state_d    = ACCESS;
                    cnt_d      = 4'(WAIT_STATES);
                    capture_en = 1'b1;
                end
            end
            ACCESS: begin
                if (!pselx) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (penable) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cap_addr_q  <= 2'd0;
            cap_write_q <= 1'b0;
            cap_wdata_q <= '0;
            wcnt_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture_en) begin
                cap_addr_q  <= paddr[1:0];
                cap_write_q <= pwrite;
                cap_wdata_q <= pwdata;
            end
            if (commit && cap_write_q && cap_addr_q != 2'd3) begin
                regs_q[cap_addr_q] <= cap_wdata_q;
                wcnt_q             <= wcnt_q + DATA_WIDTH'(1);
            end
        end
    end

    // Outputs depend only on registered state, never directly on APB inputs.
    assign pready       = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign pslave_error = pready && cap_write_q && (cap_addr_q == 2'd3);

    always_comb begin
        prdata = '0;
        if (pready && !cap_write_q) begin
            case (cap_addr_q)
                2'd0:    prdata = regs_q[0];
                2'd1:    prdata = regs_q[1];
                2'd2:    prdata = regs_q[2];
                default: prdata = wcnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// tb/tb_apb_slave_regs.sv - self-checking bench for apb_slave_regs (one slow and one zero-wait instance)
module tb_apb_slave_regs;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic [1:0] paddr  [2];
    logic       pselx  [2];
    logic       penable[2];
    logic       pwrite [2];
    logic [1:0] pwdata [2];
    logic       pready [2];
    logic [1:0] prdata [2];
    logic       perr   [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc [2];
    int ws_of [2] = '{1, 0};

    logic [1:0] m_regs [2][3];
    logic [1:0] m_wcnt [2];

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_slave_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(2), .WAIT_STATES(1), .RESET_VAL(2'd0)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr[0]), .pselx(pselx[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .pwdata(pwdata[0]), .pready(pready[0]), .prdata(prdata[0]),
        .pslave_error(perr[0]));

    apb_slave_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(2), .WAIT_STATES(0), .RESET_VAL(2'd0)) dut_fast (
        .pclk(pclk), .presetn(presetn), .paddr(paddr[1]), .pselx(pselx[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .pwdata(pwdata[1]), .pready(pready[1]), .prdata(prdata[1]),
        .pslave_error(perr[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wcnt[d] = 2'd0;
            for (int r = 0; r < 3; r++) m_regs[d][r] = 2'd0;
        end
    endtask

    task automatic idle(input int d);
        @(negedge pclk);
        pselx[d]   = 1'b0;
        penable[d] = 1'b0;
    endtask

    // One full transfer; leaves pselx asserted after the completion edge so
    // a following call produces a back-to-back setup phase.
    task automatic xfer(input int d, input logic [1:0] addr, input bit wr, input logic [1:0] wd);
        logic [1:0] exp_rd;
        bit         exp_err;
        int         waits;
        @(negedge pclk);
        pselx[d] = 1'b1; penable[d] = 1'b0;
        paddr[d] = addr; pwrite[d] = wr; pwdata[d] = wd;
        @(negedge pclk);
        penable[d] = 1'b1;
        paddr[d]   = ~addr;
        pwdata[d]  = ~wd;
        waits = 0;
        while (pready[d] !== 1'b1 && waits < 20) begin
            check("wait_prdata", prdata[d], 0);
            check("wait_error", perr[d], 0);
            waits++;
            @(negedge pclk);
        end
        check("wait_count", waits, ws_of[d]);
        exp_err = wr && (addr == 2'd3);
        if (wr)              exp_rd = 2'd0;
        else if (addr == 3)  exp_rd = m_wcnt[d];
        else                 exp_rd = m_regs[d][addr];
        check(wr ? "write_prdata" : "read_prdata", prdata[d], exp_rd);
        check("slave_error", perr[d], exp_err);
        if (wr && addr != 2'd3) begin
            m_regs[d][addr] = wd;
            m_wcnt[d]       = m_wcnt[d] + 2'd1;
        end
        @(posedge pclk);
        #1 done_cyc[d] = cyc;
    endtask

    initial begin
        int prev;
        for (int d = 0; d < 2; d++) begin
            paddr[d] = 0; pselx[d] = 0; penable[d] = 0; pwrite[d] = 0; pwdata[d] = 0;
        end
        model_reset();
        repeat (2) @(negedge pclk);
        for (int d = 0; d < 2; d++) begin
            check("reset_pready", pready[d], 0);
            check("reset_prdata", prdata[d], 0);
            check("reset_error", perr[d], 0);
        end
        presetn = 1'b1;

        for (int a = 0; a < 4; a++) begin
            xfer(0, 2'(a), 1'b0, 2'd0);
            idle(0);
        end

        xfer(0, 2'd1, 1'b1, 2'b10); idle(0);
        xfer(0, 2'd1, 1'b0, 2'd0);  idle(0);
        xfer(0, 2'd3, 1'b0, 2'd0);  idle(0);
        xfer(0, 2'd3, 1'b1, 2'b11); idle(0);
        xfer(0, 2'd3, 1'b0, 2'd0);  idle(0);

        // Counter wrap from reset: four writes return to 0, a fifth gives 1.
        @(negedge pclk); presetn = 1'b0; model_reset();
        @(negedge pclk); presetn = 1'b1;
        xfer(0, 2'd1, 1'b1, 2'd1); xfer(0, 2'd2, 1'b1, 2'd2);
        xfer(0, 2'd1, 1'b1, 2'd3); xfer(0, 2'd2, 1'b1, 2'd1);
        xfer(0, 2'd3, 1'b0, 2'd0); check("wcnt_wrap", m_wcnt[0], 0);
        xfer(0, 2'd1, 1'b1, 2'd2);
        xfer(0, 2'd3, 1'b0, 2'd0); idle(0);

        // Abort: pselx dropped in the first access cycle.
        @(negedge pclk);
        pselx[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 2'd0; pwrite[0] = 1'b1; pwdata[0] = 2'b01;
        @(negedge pclk);
        check("abort_pready_access", pready[0], 0);
        pselx[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check("abort_pready_after", pready[0], 0);
        end
        xfer(0, 2'd0, 1'b0, 2'd0);
        xfer(0, 2'd3, 1'b0, 2'd0); idle(0);

        // Asynchronous reset while pready is high, before the completion edge.
        xfer(0, 2'd0, 1'b1, 2'd3); idle(0);
        @(negedge pclk);
        pselx[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 2'd0; pwrite[0] = 1'b1; pwdata[0] = 2'd2;
        @(negedge pclk); penable[0] = 1'b1;
        @(negedge pclk);
        check("pre_reset_pready", pready[0], 1);
        #2 presetn = 1'b0;
        #1 check("async_reset_pready", pready[0], 0);
        check("async_reset_error", perr[0], 0);
        pselx[0] = 1'b0; penable[0] = 1'b0;
        model_reset();
        #1 presetn = 1'b1;
        xfer(0, 2'd0, 1'b0, 2'd0);
        xfer(0, 2'd3, 1'b0, 2'd0); idle(0);

        // Zero-wait instance: back-to-back transfers complete every 2 cycles.
        xfer(1, 2'd2, 1'b1, 2'd3);
        prev = done_cyc[1];
        for (int i = 0; i < 4; i++) begin
            xfer(1, 2'(i), 1'b0, 2'd0);
            check("b2b_spacing", done_cyc[1] - prev, 2);
            prev = done_cyc[1];
        end
        idle(1);

        for (int i = 0; i < 40; i++) begin
            xfer(0, 2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom));
            if ($urandom_range(0, 1) == 0) idle(0);
        end
        idle(0);
        for (int i = 0; i < 40; i++) begin
            xfer(1, 2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom));
        end
        idle(1);
        for (int a = 0; a < 4; a++) begin
            xfer(0, 2'(a), 1'b0, 2'd0);
            xfer(1, 2'(a), 1'b0, 2'd0);
        end
        idle(0); idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
